// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle between the burst reader, its show-ahead FIFO and the downstream beat sink.
// slave is the reader side; master is the side that drives the reader's inputs.
interface fifo_burst_reader_if #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned LEN_W  = 4
);
  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              timeout;

  modport slave (
    input  start, burst_len, fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_valid, out_data, out_last, busy, done, timeout
  );

  modport master (
    output start, burst_len, fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_last, busy, done, timeout
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Reads a fixed-length burst from a show-ahead FIFO into a registered valid/ready beat stream.
// Optional stall abort is built only when FIFO_READER_TIMEOUT_EN is defined.
module fifo_burst_reader #(
  parameter int unsigned DATA_W         = 2,
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  fifo_burst_reader_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              done_q, done_d;
  logic              rd_en_c;
  logic              drain_exit_c;

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int unsigned StallW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [StallW-1:0] StallLim = StallW'(TIMEOUT_CYCLES - 1);

  logic [StallW-1:0] stall_q, stall_d;
  logic              abort_q, abort_d;
  logic              timeout_q, timeout_d;

  // An aborted burst leaves its held beat without out_last, so it drains on any handshake.
  assign drain_exit_c = out_valid_q && bus.out_ready && (out_last_q || abort_q);
  assign bus.timeout  = timeout_q;
`else
  assign drain_exit_c = out_valid_q && bus.out_ready && out_last_q;
  assign bus.timeout  = 1'b0;
`endif

  // Pop only when the output register is free or being emptied this cycle.
  assign rd_en_c = (state_q == ST_RUN) && !bus.fifo_empty &&
                   (!out_valid_q || bus.out_ready) && (rem_q != '0);

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_data   = out_data_q;
  assign bus.done       = done_q;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
`ifdef FIFO_READER_TIMEOUT_EN
    stall_d     = '0;
    abort_d     = abort_q;
`endif

    if (rd_en_c) begin
      out_data_d  = bus.fifo_rd_data;
      out_valid_d = 1'b1;
      rem_d       = rem_q - LEN_W'(1);
      out_last_d  = (rem_q == LEN_W'(1));
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.burst_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            rem_d   = bus.burst_len;
          end
        end
      end
      ST_RUN: begin
        if (rd_en_c && (rem_q == LEN_W'(1))) state_d = ST_DRAIN;
`ifdef FIFO_READER_TIMEOUT_EN
        // A beat handshaking on the abort edge is already gone, so skip DRAIN then.
        if (bus.fifo_empty) begin
          if (stall_q == StallLim) begin
            abort_d = 1'b1;
            state_d = out_valid_d ? ST_DRAIN : ST_DONE;
          end else begin
            stall_d = stall_q + StallW'(1);
          end
        end
`endif
      end
      ST_DRAIN: begin
        if (drain_exit_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef FIFO_READER_TIMEOUT_EN
        abort_d = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
`ifdef FIFO_READER_TIMEOUT_EN
    timeout_d = done_d && abort_d;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
`ifdef FIFO_READER_TIMEOUT_EN
      stall_q     <= '0;
      abort_q     <= 1'b0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
`ifdef FIFO_READER_TIMEOUT_EN
      stall_q     <= stall_d;
      abort_q     <= abort_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: directed bursts against a queue-backed show-ahead FIFO.
// Expected beats are queued by the stimulus and checked by an independent output monitor.
module tb_fifo_burst_reader;

  localparam int unsigned DATA_W = 2;
  localparam int unsigned LEN_W  = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    int                cyc;
  } beat_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   done_cnt;
  logic prev_done;
  bit   rd_seen;

  logic [DATA_W-1:0] fifo_m[$];
  beat_t             exp_q[$];
  beat_t             mon_e;

  fifo_burst_reader_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  fifo_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic refresh();
    bus.fifo_empty   = (fifo_m.size() == 0);
    bus.fifo_rd_data = (fifo_m.size() != 0) ? fifo_m[0] : '0;
  endtask

  task automatic push_fifo(input logic [DATA_W-1:0] v);
    fifo_m.push_back(v);
    refresh();
  endtask

  task automatic exp_beat(input logic [DATA_W-1:0] d, input logic l, input int c);
    beat_t b;
    b.data = d;
    b.last = l;
    b.cyc  = c;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [LEN_W-1:0] len, output int s);
    bus.burst_len = len;
    bus.start     = 1'b1;
    s             = cyc;
    tick();
    bus.start     = 1'b0;
  endtask

  // Bounded wait for done; an expired bound counts as a failed check.
  task automatic wait_done(input int max, output int at, output logic to);
    at = -1;
    to = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.done) begin
        at = cyc;
        to = bus.timeout;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      $display("FAIL done_wait: no done within %0d cycles", max);
    end
  endtask

  // FIFO model: pops on the edge where the reader asserted fifo_rd_en.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      rd_seen = 1'b1;
      if (fifo_m.size() != 0) void'(fifo_m.pop_front());
    end
    #1 refresh();
  end

  // Output monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.fifo_empty) chk("rd_en_when_empty", 32'(bus.fifo_rd_en), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got data %0d last %0d, expected no beat", bus.out_data, bus.out_last);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", 32'(bus.out_data), 32'(mon_e.data));
          chk("beat_last", 32'(bus.out_last), 32'(mon_e.last));
          if (mon_e.cyc >= 0) chk("beat_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    int   s;
    int   at;
    logic to;
    int   dc;

    cyc = 0; n_checks = 0; n_pass = 0; done_cnt = 0; prev_done = 1'b0; rd_seen = 1'b0;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.burst_len = '0;
    bus.out_ready = 1'b1;
    refresh();
    repeat (2) tick();

    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_timeout", 32'(bus.timeout), 32'd0);
    chk("reset_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("reset_out_last", 32'(bus.out_last), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Full burst of 3 at full rate
    push_fifo(2'd1); push_fifo(2'd2); push_fifo(2'd3);
    issue(4'd3, s);
    exp_beat(2'd1, 1'b0, s + 2);
    exp_beat(2'd2, 1'b0, s + 3);
    exp_beat(2'd3, 1'b1, s + 4);
    wait_done(20, at, to);
    chk("t1_done_cycle", 32'(at), 32'(s + 5));
    chk("t1_timeout", 32'(to), 32'd0);
    @(negedge clk);
    chk("t1_done_low", 32'(bus.done), 32'd0);
    tick(); tick();
    chk("t1_idle", 32'(bus.busy), 32'd0);

    // Short burst leaves the third entry in the FIFO
    push_fifo(2'd1); push_fifo(2'd2); push_fifo(2'd3);
    issue(4'd2, s);
    exp_beat(2'd1, 1'b0, s + 2);
    exp_beat(2'd2, 1'b1, s + 3);
    wait_done(20, at, to);
    chk("t2_done_cycle", 32'(at), 32'(s + 4));
    chk("t2_fifo_empty", 32'(bus.fifo_empty), 32'd0);
    chk("t2_fifo_level", 32'(fifo_m.size()), 32'd1);
    chk("t2_fifo_head", 32'(bus.fifo_rd_data), 32'd3);
    tick(); tick();
    issue(4'd1, s);
    exp_beat(2'd3, 1'b1, s + 2);
    wait_done(20, at, to);
    chk("t2b_done_cycle", 32'(at), 32'(s + 3));
    tick(); tick();

    // Downstream stall on beat 2, with a start pulse that must be ignored
    push_fifo(2'd1); push_fifo(2'd2); push_fifo(2'd3);
    issue(4'd3, s);
    exp_beat(2'd1, 1'b0, s + 2);
    exp_beat(2'd2, 1'b0, s + 7);
    exp_beat(2'd3, 1'b1, s + 8);
    tick(); tick();
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    bus.burst_len = 4'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_hold_data", 32'(bus.out_data), 32'd2);
      chk("t3_hold_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.start = 1'b0;
    wait_done(20, at, to);
    chk("t3_done_cycle", 32'(at), 32'(s + 9));
    chk("t3_fifo_level", 32'(fifo_m.size()), 32'd0);
    tick(); tick();

    // Zero-length burst with data waiting in the FIFO
    push_fifo(2'd3);
    rd_seen = 1'b0;
    issue(4'd0, s);
    wait_done(10, at, to);
    chk("t4_done_cycle", 32'(at), 32'(s + 1));
    tick(); tick();
    chk("t4_no_pop", 32'(rd_seen), 32'd0);
    chk("t4_fifo_level", 32'(fifo_m.size()), 32'd1);
    issue(4'd1, s);
    exp_beat(2'd3, 1'b1, s + 2);
    wait_done(20, at, to);
    tick(); tick();

    // Empty FIFO stall
    dc = done_cnt;
    issue(4'd2, s);
`ifdef FIFO_READER_TIMEOUT_EN
    wait_done(40, at, to);
    chk("t5_timeout_done_cycle", 32'(at), 32'(s + 17));
    chk("t5_timeout_flag", 32'(to), 32'd1);
    tick(); tick();
    chk("t5_idle", 32'(bus.busy), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t5_busy_held", 32'(bus.busy), 32'd1);
      tick();
    end
    chk("t5_no_done", 32'(done_cnt), 32'(dc));
    exp_beat(2'd1, 1'b0, -1);
    exp_beat(2'd2, 1'b1, -1);
    push_fifo(2'd1); push_fifo(2'd2);
    wait_done(20, at, to);
    chk("t5_late_timeout", 32'(to), 32'd0);
    tick(); tick();
`endif

    // Asynchronous reset while a beat is held
    push_fifo(2'd1); push_fifo(2'd2); push_fifo(2'd3);
    bus.out_ready = 1'b0;
    issue(4'd3, s);
    tick();
    chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    exp_q.delete();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_async_busy", 32'(bus.busy), 32'd0);
    chk("t6_async_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    #2 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t6_post_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("t6_post_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("t6_fifo_kept", 32'(fifo_m.size()), 32'd2);
    fifo_m.delete();
    refresh();
    tick(); tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
